// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_arbiter
// Description : Bank of JK flops shared by NREQ requesters; a round-robin
//               arbiter executes one single-bit j/k command per 2-cycle slot.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    cmd,
    input  logic [IDXW*NREQ-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 err,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_bar
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [1:0]       jk_q, jk_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] bank_q, bank_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [1:0]       jk_sel;
    logic [IDXW-1:0]  idx_sel;
    int               cand;

    // Round-robin scan starting at ptr; the first active requester wins.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        jk_sel  = '0;
        idx_sel = '0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_q) + i) % NREQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win     = cand[IDW-1:0];
                jk_sel  = cmd[2*cand +: 2];
                idx_sel = idx[IDXW*cand +: IDXW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        jk_d    = jk_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_EXEC;
                    id_d    = win;
                    jk_d    = jk_sel;
                    idx_d   = idx_sel;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                ptr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + IDW'(1);
                // An out-of-range index matches no bit, so the bank holds.
                for (int b = 0; b < WIDTH; b++) begin
                    if (int'(idx_q) == b) begin
                        case (jk_q)
                            2'b10:   bank_d[b] = 1'b1;
                            2'b01:   bank_d[b] = 1'b0;
                            2'b11:   bank_d[b] = ~bank_q[b];
                            default: bank_d[b] = bank_q[b];
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            jk_q    <= '0;
            idx_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            jk_q    <= jk_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        busy = (state_q == S_EXEC);
        err  = busy && (int'(idx_q) >= WIDTH);
        for (int r = 0; r < NREQ; r++) begin
            gnt[r] = busy && (int'(id_q) == r);
        end
    end

    assign q     = bank_q;
    assign q_bar = ~bank_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_arbiter
// Description : Directed, table-driven bench for jk_bank_arbiter (WIDTH 8 and 6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  cmd = '0;
    logic [11:0] idx = '0;

    logic [3:0]  gnt8, gnt6;
    logic        busy8, busy6, err8, err6;
    logic [7:0]  q8, qb8;
    logic [5:0]  q6, qb6;

    int checks = 0;
    int failures = 0;

    jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt8), .busy(busy8), .err(err8), .q(q8), .q_bar(qb8)
    );

    jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt6), .busy(busy6), .err(err6), .q(q6), .q_bar(qb6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         rid;
        logic [1:0] jk;
        logic [2:0] bi;
        logic [3:0] egnt;
        logic [7:0] eq;
        logic       eerr6;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input logic [3:0] exp, input string name, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (gnt8 == 4'b0 && cyc < 6);
        chk(name, {28'b0, gnt8}, {28'b0, exp});
    endtask

    initial begin
        int cyc;

        // Unselected slices carry toggle-bit-5 so a wrong slice pick shows up.
        vecs[0] = '{4'b0010, 1, 2'b10, 3'd3, 4'b0010, 8'h08, 1'b0};
        vecs[1] = '{4'b0010, 1, 2'b11, 3'd3, 4'b0010, 8'h00, 1'b0};
        vecs[2] = '{4'b0010, 1, 2'b11, 3'd3, 4'b0010, 8'h08, 1'b0};
        vecs[3] = '{4'b1000, 3, 2'b01, 3'd3, 4'b1000, 8'h00, 1'b0};
        vecs[4] = '{4'b0001, 0, 2'b10, 3'd7, 4'b0001, 8'h80, 1'b1};
        vecs[5] = '{4'b0100, 2, 2'b00, 3'd7, 4'b0100, 8'h80, 1'b1};
        vecs[6] = '{4'b0001, 0, 2'b10, 3'd6, 4'b0001, 8'hC0, 1'b1};

        #1;
        chk("reset_q", {24'b0, q8}, 32'h00);
        chk("reset_qbar", {24'b0, qb8}, 32'hFF);
        chk("reset_gnt", {28'b0, gnt8}, 32'h0);
        chk("reset_busy_err", {30'b0, busy8, err8}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            cmd = 8'hFF;
            cmd[2*vecs[v].rid +: 2] = vecs[v].jk;
            idx = {4{3'd5}};
            idx[3*vecs[v].rid +: 3] = vecs[v].bi;
            req = vecs[v].req;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_gnt", v), {28'b0, gnt8}, {28'b0, vecs[v].egnt});
            chk($sformatf("v%0d_busy", v), {31'b0, busy8}, 32'h1);
            chk($sformatf("v%0d_err8", v), {31'b0, err8}, 32'h0);
            chk($sformatf("v%0d_gnt6", v), {28'b0, gnt6}, {28'b0, vecs[v].egnt});
            chk($sformatf("v%0d_err6", v), {31'b0, err6}, {31'b0, vecs[v].eerr6});
            req = 4'b0;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_q", v), {24'b0, q8}, {24'b0, vecs[v].eq});
            chk($sformatf("v%0d_qbar", v), {24'b0, qb8}, {24'b0, ~vecs[v].eq});
            chk($sformatf("v%0d_q6", v), {26'b0, q6}, {26'b0, vecs[v].eq[5:0]});
            chk($sformatf("v%0d_idle", v), {27'b0, gnt8, busy8}, 32'h0);
        end

        // Abort: reset lands inside the EXEC cycle of a set on bit 5.
        cmd = 8'hFF;
        cmd[3:2] = 2'b10;
        idx = {4{3'd5}};
        req = 4'b0010;
        @(posedge clk);
        #1;
        chk("abort_exec_busy", {31'b0, busy8}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_q", {24'b0, q8}, 32'h00);
        chk("abort_qbar", {24'b0, qb8}, 32'hFF);
        chk("abort_gnt_busy_err", {26'b0, gnt8, busy8, err8}, 32'h0);
        req = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("abort_no_gnt", {27'b0, gnt8, busy8}, 32'h0);
            chk("abort_q5", {31'b0, q8[5]}, 32'h0);
        end

        // Pointer restarts at 0 after reset: r0 before r3, then wrap back.
        cmd = 8'h00;
        idx = '0;
        req = 4'b1001;
        wait_gnt(4'b0001, "post_reset_first", cyc);
        req[0] = 1'b0;
        wait_gnt(4'b1000, "post_reset_second", cyc);
        req[3] = 1'b0;

        // Fairness: four simultaneous sets on bits 0..3.
        cmd = 8'b10101010;
        idx = {3'd3, 3'd2, 3'd1, 3'd0};
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(4'(1 << k), $sformatf("fair_gnt%0d", k), cyc);
            if (k > 0) chk($sformatf("fair_gap%0d", k), cyc, 32'd2);
            req[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("fair_q", {24'b0, q8}, 32'h0F);

        // Rotation: after r2, r0 wins over a re-requesting r2.
        cmd = 8'h00;
        req = 4'b0100;
        wait_gnt(4'b0100, "rot_r2", cyc);
        req = 4'b0101;
        wait_gnt(4'b0001, "rot_r0_first", cyc);
        chk("rot_gap", cyc, 32'd2);
        req = 4'b0100;
        wait_gnt(4'b0100, "rot_r2_again", cyc);
        req = 4'b0;
        @(posedge clk);
        #1;
        chk("rot_q_hold", {24'b0, q8}, 32'h0F);
        chk("rot_idle", {27'b0, gnt8, busy8}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shared bank of WIDTH JK flip-flops, accessed by NREQ requesters.
- Each requester issues a single-bit command (hold/set/reset/toggle) on one bank bit.
- A round-robin arbiter serialises access: one command executes per 2-cycle transaction.
- Sits between control agents and the JK flop storage and sequences all j/k activity on the bank.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK flip-flops in the bank
- IDXW, 3, width of a bit index; must be >= clog2(WIDTH)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request, level; held until that requester's gnt
- cmd  input  2*NREQ  per-requester {j,k}; slice r = cmd[2r+1:2r]
- idx  input  IDXW*NREQ  per-requester target bit; slice r = idx[IDXW*r+IDXW-1:IDXW*r]
- gnt  output  NREQ  one-hot grant/ack pulse, one cycle
- busy  output  1  high while a transaction is executing
- err  output  1  one-cycle pulse with gnt when the latched idx >= WIDTH
- q  output  WIDTH  bank state
- q_bar  output  WIDTH  always ~q

Behaviour:
- Reset (rst_n low, asynchronous): q=0, q_bar=all 1s, gnt=0, busy=0, err=0, rr pointer=0, state=IDLE.
- Reset asserted mid-EXEC aborts the transaction: no bank update, no gnt after release.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is high, the winner is the first r with req[r]=1, scanning ptr, ptr+1, ... mod NREQ.
  - Latch winner id, cmd[r] and idx[r]; go to EXEC.
  - If no req bit is high, stay in IDLE.
- EXEC:
  - busy=1 and gnt[id]=1 for exactly this cycle.
  - err=1 this cycle if the latched idx >= WIDTH.
  - At the edge ending EXEC, bit q[idx] updates from the latched {j,k}:
    - 00 hold
    - 10 set (q=1)
    - 01 reset (q=0)
    - 11 toggle (q=~q)
  - All other bits hold.
  - Out-of-range idx: no bit changes; the command is still granted.
  - At the same edge, ptr = (id+1) mod NREQ; next state is IDLE.
- Latency:
  - req rising in IDLE produces gnt on the next cycle.
  - The new q is visible the cycle after gnt.
  - Throughput is one command per 2 cycles.
- Handshake:
  - A requester deasserts req, or presents its next command, in the cycle after gnt.
  - A req still high after its gnt is treated as a new request and competes again under round-robin; no requester is granted twice while another is waiting.
  - cmd/idx changes after latching do not affect the executing transaction.
  - A req that drops before it is sampled in IDLE is lost; no memory of it is kept.
- Output timing: q, q_bar, gnt, busy and err are all registered or derived directly from registered state. There are no combinational paths from req/cmd/idx to outputs.
- Pointer wrap: when id = NREQ-1, ptr becomes 0.

Test Plan:
- Reset check: assert rst_n=0 mid-run -> immediately q=8'h00, q_bar=8'hFF, gnt=0, busy=0. After release, the first grant goes to the lowest-numbered active requester (ptr=0).
- Set then toggle: req[1] with cmd=10, idx=3 -> gnt=4'b0010 one cycle later, then q=8'h08. Next, cmd=11, idx=3 -> q=8'h00. Repeat the toggle -> q=8'h08.
- Fairness: all four req held high, each with cmd=10 and distinct idx 0..3 -> gnt sequence 0001, 0010, 0100, 1000 on alternate cycles; final q=8'h0F.
- Rotation: after granting requester 2, drive req=4'b0101 -> requester 0 is granted before requester 2 (ptr=3 wraps to 0), then requester 2.
- Out-of-range index: idx=7 is legal; set WIDTH=6 and idx=6 -> gnt and err pulse together, q unchanged.
- Abort: drop rst_n during the EXEC cycle of a set command on bit 5 -> q[5] stays 0, no further gnt, state is IDLE after release.
